// File: rtl/vga_timing_640x480_pkg.sv
// ============================================================================
// vga_timing_640x480_pkg : shared 640x480@60 timing constants, lock-FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_timing_640x480_pkg;

  localparam int unsigned VGA_H_SYNC_BP = 144;
  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_TOTAL   = 800;
  localparam int unsigned VGA_V_SYNC_BP = 35;
  localparam int unsigned VGA_V_ACTIVE  = 480;
  localparam int unsigned VGA_V_TOTAL   = 525;

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_edge.sv
// ============================================================================
// vga_sync_edge : strobe-qualified history of an active-low sync, fall pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_sync,
  output logic o_fall
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d = hist_q;
    if (i_stb) hist_d = i_sync;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) hist_q <= 1'b1;
    else       hist_q <= hist_d;
  end

  assign o_fall = i_stb & hist_q & ~i_sync;

endmodule

`default_nettype wire

// File: rtl/vga_sync_monitor.sv
// ============================================================================
// vga_sync_monitor : recovers x/y/active from HS/VS, measures line and frame
//                    lengths and reports lock against the nominal timing
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_monitor
  import vga_timing_640x480_pkg::*;
#(
  parameter int unsigned H_SYNC_BP = VGA_H_SYNC_BP,
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL   = VGA_H_TOTAL,
  parameter int unsigned V_SYNC_BP = VGA_V_SYNC_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL   = VGA_V_TOTAL
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_locked,
  output logic [9:0] o_h_total,
  output logic [9:0] o_v_total,
  output logic       o_err
);

  localparam logic [9:0]  H_START = 10'(H_SYNC_BP);
  localparam logic [9:0]  H_STOP  = 10'(H_SYNC_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC_BP);
  localparam logic [9:0]  V_STOP  = 10'(V_SYNC_BP + V_ACTIVE);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);

  logic hs_fall;
  logic vs_fall;

  vga_sync_edge u_hs_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_stb  (i_pix_stb),
    .i_sync (i_hs),
    .o_fall (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_stb  (i_pix_stb),
    .i_sync (i_vs),
    .o_fall (vs_fall)
  );

  lock_state_e state_q, state_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [9:0]  h_total_q, h_total_d;
  logic [9:0]  v_total_q, v_total_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        active_q, active_d;
  logic        err_q, err_d;
  logic        bad_q, bad_d;

  // 11-bit lengths so a saturated counter (1023+1) can never alias a good length
  logic [10:0] line_len;
  logic [10:0] frame_len;
  logic        line_bad;
  logic        frame_ok;

  assign line_len  = {1'b0, hcnt_q} + 11'd1;
  assign frame_len = {1'b0, vcnt_q} + 11'd1;
  assign line_bad  = hs_fall && (line_len != H_LEN);
  assign frame_ok  = (frame_len == V_LEN);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    x_d       = x_q;
    y_d       = y_q;
    active_d  = active_q;
    bad_d     = bad_q;
    err_d     = 1'b0;

    if (i_pix_stb) begin
      if (hs_fall) begin
        h_total_d = 10'(line_len);
        hcnt_d    = '0;
        vcnt_d    = sat_inc(vcnt_q);
      end else begin
        hcnt_d    = sat_inc(hcnt_q);
      end

      if (vs_fall) begin
        v_total_d = 10'(frame_len);
        vcnt_d    = '0;
      end

      active_d = (hcnt_d >= H_START) && (hcnt_d < H_STOP) &&
                 (vcnt_d >= V_START) && (vcnt_d < V_STOP);
      x_d = active_d ? (hcnt_d - H_START) : '0;
      y_d = active_d ? 9'(vcnt_d - V_START) : '0;

      case (state_q)
        ST_SEARCH: begin
          if (vs_fall) begin
            state_d = ST_CHECK;
            bad_d   = 1'b0;
          end
        end
        ST_CHECK: begin
          if (line_bad) bad_d = 1'b1;
          if (vs_fall) begin
            if (!bad_q && !line_bad && frame_ok) state_d = ST_LOCKED;
            bad_d = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (line_bad || (vs_fall && !frame_ok) || (hcnt_d == CNT_MAX)) begin
            state_d = ST_SEARCH;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_SEARCH;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      x_q       <= x_d;
      y_q       <= y_d;
      active_q  <= active_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
    end
  end

  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_active  = active_q;
  assign o_locked  = (state_q == ST_LOCKED);
  assign o_h_total = h_total_q;
  assign o_v_total = v_total_q;
  assign o_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// ============================================================================
// tb_vga_sync_monitor : randomized-gap sync stimulus against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_monitor;

  localparam int HSB = 4;
  localparam int HA  = 8;
  localparam int HT  = 16;
  localparam int VSB = 2;
  localparam int VA  = 4;
  localparam int VT  = 8;

  logic       clk = 1'b0;
  logic       rst, stb, hs, vs;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_active, o_locked, o_err;
  logic [9:0] o_h_total, o_v_total;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_SYNC_BP (HSB), .H_ACTIVE (HA), .H_TOTAL (HT),
    .V_SYNC_BP (VSB), .V_ACTIVE (VA), .V_TOTAL (VT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_pix_stb (stb),
    .i_hs      (hs),
    .i_vs      (vs),
    .o_x       (o_x),
    .o_y       (o_y),
    .o_active  (o_active),
    .o_locked  (o_locked),
    .o_h_total (o_h_total),
    .o_v_total (o_v_total),
    .o_err     (o_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: position counted as strobes since the last HS fall and
  // lines since the last VS fall; lock tracked as "armed / frame clean / locked".
  int m_since_hs, m_lines;
  bit m_prev_hs, m_prev_vs, m_armed, m_clean, m_locked;
  int e_x, e_y, e_ht, e_vt;
  bit e_active, e_locked, e_err;

  task automatic model_step(input bit r, input bit s, input bit h, input bit v);
    int  old_lines, len, flen;
    bit  hf, vf, line_ok;
    e_err = 1'b0;
    if (r) begin
      m_since_hs = 0; m_lines = 0; m_prev_hs = 1; m_prev_vs = 1;
      m_armed = 0; m_clean = 0; m_locked = 0;
      e_x = 0; e_y = 0; e_ht = 0; e_vt = 0; e_active = 0; e_locked = 0;
      return;
    end
    if (!s) return;
    hf = m_prev_hs && !h;
    vf = m_prev_vs && !v;
    m_prev_hs = h;
    m_prev_vs = v;
    old_lines = m_lines;
    line_ok   = 1'b1;
    if (hf) begin
      len        = m_since_hs + 1;
      e_ht       = len % 1024;
      line_ok    = (len == HT);
      m_since_hs = 0;
      m_lines    = (m_lines < 1023) ? m_lines + 1 : 1023;
    end else begin
      m_since_hs = (m_since_hs < 1023) ? m_since_hs + 1 : 1023;
    end
    flen = old_lines + 1;
    if (vf) begin
      e_vt    = flen % 1024;
      m_lines = 0;
    end
    if (m_locked) begin
      if (!line_ok || (vf && flen != VT) || m_since_hs == 1023) begin
        m_locked = 0; m_armed = 0; e_err = 1'b1;
      end
    end else if (m_armed) begin
      if (!line_ok) m_clean = 0;
      if (vf) begin
        if (m_clean && flen == VT) m_locked = 1;
        m_clean = 1;
      end
    end else if (vf) begin
      m_armed = 1; m_clean = 1;
    end
    e_active = (m_since_hs >= HSB) && (m_since_hs < HSB + HA) &&
               (m_lines >= VSB) && (m_lines < VSB + VA);
    e_x      = e_active ? m_since_hs - HSB : 0;
    e_y      = e_active ? m_lines - VSB : 0;
    e_locked = m_locked;
  endtask

  // Sync source: HS low for 2 strobes at line start, VS low for lines 0..1.
  int g_pos = 0, g_line = 0, g_len = HT, g_vsf = 0;
  bit g_hold = 0, g_rand = 0;

  task automatic gen_emit();
    if (g_hold) begin
      hs = 1'b1; vs = 1'b1;
      return;
    end
    if (g_pos == 0 && g_line == 0) g_vsf++;
    hs = (g_pos < 2) ? 1'b0 : 1'b1;
    vs = (g_line < 2) ? 1'b0 : 1'b1;
    g_pos++;
    if (g_pos >= g_len) begin
      g_pos = 0;
      if (g_line + 1 >= VT || (g_rand && g_line + 1 == VT - 1 && $urandom_range(0, 3) == 0))
        g_line = 0;
      else
        g_line = g_line + 1;
      g_len = (g_rand && $urandom_range(0, 5) == 0) ? HT - 2 + $urandom_range(0, 4) : HT;
    end
  endtask

  bit prev_r = 1'b1;
  int err_seen = 0;
  int lock_vsf = -1;

  task automatic cycle(input bit s, input bit r);
    @(negedge clk);
    chk("x", o_x, e_x);
    chk("y", o_y, e_y);
    chk("active", o_active, e_active);
    chk("locked", o_locked, e_locked);
    chk("err", o_err, e_err);
    chk("h_total", o_h_total, e_ht);
    chk("v_total", o_v_total, e_vt);
    if (prev_r) begin
      chk("rst_x", o_x, 0);
      chk("rst_active", o_active, 0);
      chk("rst_locked", o_locked, 0);
      chk("rst_h_total", o_h_total, 0);
      chk("rst_v_total", o_v_total, 0);
    end
    if (o_err === 1'b1) err_seen++;
    if (o_locked === 1'b1 && lock_vsf < 0) lock_vsf = g_vsf;
    prev_r = r;
    rst    = r;
    stb    = s && !r;
    if (stb) gen_emit();
    model_step(r, stb, hs, vs);
  endtask

  task automatic pix(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
    end
  endtask

  task automatic run_until(input int line, input int pos);
    int guard = 0;
    while (!(g_line == line && g_pos == pos) && guard < 5000) begin
      pix(1);
      guard++;
    end
    if (guard >= 5000) chk("run_until_timeout", guard, 0);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  int err_before;

  initial begin
    rst = 1'b1; stb = 1'b0; hs = 1'b1; vs = 1'b1;
    model_step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    cycle(1'b0, 1'b0);

    // Ideal input from reset: lock follows the second VS fall.
    pix(3 * VT * HT);
    chk("lock_vs_count", lock_vsf, 2);
    chk("ideal_h_total", o_h_total, HT);
    chk("ideal_v_total", o_v_total, VT);
    chk("ideal_no_err", err_seen, 0);

    // One short line while locked.
    run_until(3, 0);
    g_len = HT - 1;
    err_before = err_seen;
    pix(HT - 1);
    pix(1);
    peek();
    chk("short_h_total", o_h_total, HT - 1);
    chk("short_err", o_err, 1);
    chk("short_unlock", o_locked, 0);
    pix(3 * VT * HT);
    chk("short_err_once", err_seen - err_before, 1);
    chk("short_relock", o_locked, 1);

    // HS held high with vcnt inside the active band: saturation, no wrap.
    run_until(3, 0);
    err_before = err_seen;
    g_hold = 1'b1;
    pix(1100);
    chk("sat_err_once", err_seen - err_before, 1);
    chk("sat_unlock", o_locked, 0);
    chk("sat_no_active", o_active, 0);
    g_hold = 1'b0;
    pix(3 * VT * HT);
    chk("sat_relock", o_locked, 1);

    // Reset mid-frame while locked.
    run_until(4, 5);
    cycle(1'b0, 1'b1);
    g_vsf = 0;
    lock_vsf = -1;
    pix(3 * VT * HT);
    chk("rst_relock_vs_count", lock_vsf, 2);

    // Strobe held low for 100 cycles mid-line inside the active region.
    run_until(3, 7);
    repeat (100) cycle(1'b0, 1'b0);
    chk("freeze_active", o_active, 1);
    pix(2 * VT * HT);
    chk("freeze_locked", o_locked, 1);

    // Random line/frame length disturbances, then clean recovery.
    g_rand = 1'b1;
    pix(8 * VT * HT);
    g_rand = 1'b0;
    run_until(0, 0);
    pix(3 * VT * HT);
    chk("final_locked", o_locked, 1);
    chk("final_h_total", o_h_total, HT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
